// File: rtl/seg_scan_arbiter_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan arbiter.
//   seg_state_e  - arbiter FSM state (SCAN, OVERLAY, COOLDOWN)
//   NUM_DIGITS   - digit positions scanned per frame
//   SEG_W        - segments per digit
//   POS_NONE     - digit-enable value that lights no position (active-low)
//   COOL_TICKS   - scan ticks spent in COOLDOWN before new grants
`timescale 1ns/1ps
package seg_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int SEG_W = 7;
  localparam logic [NUM_DIGITS-1:0] POS_NONE = 8'hFF;
  localparam int COOL_TICKS = 8;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    OVERLAY  = 2'd1,
    COOLDOWN = 2'd2
  } seg_state_e;
endpackage

// File: rtl/seg_scan_arbiter_if.sv
// seg_scan_arbiter_if: overlay request channel between a message source
// (master) and the scan arbiter (slave).
//   msg_req   - request, level, held by the master until msg_gnt is seen
//   msg_seg   - overlay digits, [7i+6:7i] = position i; sampled on grant
//   msg_gnt   - one-cycle grant pulse, same cycle as the accepted msg_req
//   msg_busy  - high from the cycle after the grant until the overlay ends
//   state_dbg - arbiter FSM state, for observation only
//
// Handshake: msg_req acts as valid and msg_gnt as the matching ready. A
// transfer happens in exactly the cycle where both are high; msg_seg is
// captured at that edge and the master may drop or change msg_req/msg_seg
// from the following cycle. msg_req may not be withdrawn before the grant.
`timescale 1ns/1ps
interface seg_scan_arbiter_if;
  import seg_pkg::*;

  logic                          msg_req;
  logic [NUM_DIGITS*SEG_W-1:0]   msg_seg;
  logic                          msg_gnt;
  logic                          msg_busy;
  seg_state_e                    state_dbg;

  modport master (
    output msg_req, msg_seg,
    input  msg_gnt, msg_busy, state_dbg
  );

  modport slave (
    input  msg_req, msg_seg,
    output msg_gnt, msg_busy, state_dbg
  );
endinterface

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: free-running scan divider with blanking window.
//   clk   - rising-edge clock
//   rst   - synchronous, active-low reset (divider to 0)
//   tick  - high in the cycle the divider equals CLK_DIV-1
//   blank - high for the first BLANK_CYC cycles of every scan slot
// The blanking window is the divider phase itself: the BLANK_CYC cycles
// following a tick are exactly divider counts 0..BLANK_CYC-1, so no second
// counter is needed. Count 0 straight out of reset is blanked as well.
`timescale 1ns/1ps
module seg_scan_timer #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic blank
);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;

  assign tick  = (div_cnt == CW'(CLK_DIV - 1));
  assign blank = (div_cnt < CW'(BLANK_CYC));

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: multiplexes two players' 4-digit scores onto an 8-digit
// seven-segment display and lets a message source take over the whole
// display for OVL_TICKS scan ticks, followed by a COOLDOWN of 8 ticks in
// which further requests are ignored.
//   clk, rst      - clock, synchronous active-low reset
//   p1_seg        - player-1 digits, shown on positions 4..7
//   p2_seg        - player-2 digits, shown on positions 0..3
//   seg_display   - segment drive, active-high
//   seg_position  - digit enable, one-hot active-low, 8'hFF = none
//   mbus          - overlay request channel (slave side)
// The scan divider and position index never stop or restart on a state
// change; only the digit source changes.
`timescale 1ns/1ps
module seg_scan_arbiter
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 4,
  parameter int OVL_TICKS = 2048
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4*SEG_W-1:0]          p1_seg,
  input  logic [4*SEG_W-1:0]          p2_seg,
  output logic [SEG_W-1:0]            seg_display,
  output logic [NUM_DIGITS-1:0]       seg_position,
  seg_scan_arbiter_if.slave           mbus
);
  localparam int TC_MAX = (OVL_TICKS > COOL_TICKS) ? OVL_TICKS : COOL_TICKS;
  localparam int TCW = (TC_MAX > 2) ? $clog2(TC_MAX) : 1;

  logic                          tick;
  logic                          blank;
  logic [2:0]                    idx;
  logic [4*SEG_W-1:0]            snap_p1;
  logic [4*SEG_W-1:0]            snap_p2;
  logic [NUM_DIGITS*SEG_W-1:0]   ovl_q;
  seg_state_e                    state;
  logic [TCW-1:0]                tick_cnt;
  logic                          busy_q;
  logic                          grant;

  seg_scan_timer #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .blank (blank)
  );

  // Position index and score snapshots advance together on every tick, so
  // the digit on screen can only change at a slot boundary.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx     <= '0;
      snap_p1 <= '0;
      snap_p2 <= '0;
    end else if (tick) begin
      idx     <= idx + 3'd1;
      snap_p1 <= p1_seg;
      snap_p2 <= p2_seg;
    end
  end

  // Grant is combinational so it lands in the same cycle as the request
  // that wins; it is masked during reset.
  assign grant = rst && (state == SCAN) && mbus.msg_req;

  // tick_cnt counts ticks inside OVERLAY and COOLDOWN. The grant cycle is
  // still SCAN, so a tick coincident with the grant is never counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= SCAN;
      tick_cnt <= '0;
      busy_q   <= 1'b0;
      ovl_q    <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (mbus.msg_req) begin
            state    <= OVERLAY;
            ovl_q    <= mbus.msg_seg;
            busy_q   <= 1'b1;
            tick_cnt <= '0;
          end
        end
        OVERLAY: begin
          if (tick) begin
            if (tick_cnt == TCW'(OVL_TICKS - 1)) begin
              state    <= COOLDOWN;
              busy_q   <= 1'b0;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + TCW'(1);
            end
          end
        end
        COOLDOWN: begin
          if (tick) begin
            if (tick_cnt == TCW'(COOL_TICKS - 1)) begin
              state    <= SCAN;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + TCW'(1);
            end
          end
        end
        default: begin
          state    <= SCAN;
          busy_q   <= 1'b0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  assign mbus.msg_gnt   = grant;
  assign mbus.msg_busy  = busy_q;
  assign mbus.state_dbg = state;

  // Digit source: overlay latch in OVERLAY, otherwise the score snapshots
  // (index bit 2 selects player 1 on the upper four positions).
  always_comb begin
    seg_display  = '0;
    seg_position = POS_NONE;
    if (!blank) begin
      seg_position = ~(NUM_DIGITS'(1) << idx);
      if (state == OVERLAY) begin
        seg_display = ovl_q[idx*SEG_W +: SEG_W];
      end else if (idx[2]) begin
        seg_display = snap_p1[idx[1:0]*SEG_W +: SEG_W];
      end else begin
        seg_display = snap_p2[idx[1:0]*SEG_W +: SEG_W];
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_arbiter.sv
// tb_seg_scan_arbiter: directed bench for seg_scan_arbiter with
// CLK_DIV=4, BLANK_CYC=1, OVL_TICKS=16. Inputs change on the falling edge,
// outputs are sampled on the falling edge. n counts rising edges since the
// last reset release, so divider phase = n%4 and position = (n/4)%8.
`timescale 1ns/1ps
module tb_seg_scan_arbiter;
  import seg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] p1_seg;
  logic [27:0] p2_seg;
  logic [6:0]  seg_display;
  logic [7:0]  seg_position;

  int          n;
  int          tests;
  int          fails;
  logic [27:0] snap_p1;
  logic [27:0] snap_p2;

  seg_scan_arbiter_if mif ();

  seg_scan_arbiter #(
    .CLK_DIV   (4),
    .BLANK_CYC (1),
    .OVL_TICKS (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .p1_seg       (p1_seg),
    .p2_seg       (p2_seg),
    .seg_display  (seg_display),
    .seg_position (seg_position),
    .mbus         (mif.slave)
  );

  // clock block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s (n=%0d): got %0h, expected %0h", tag, n, got, exp);
    end
  endtask

  // One clock: the reference snapshot follows the tick in the cycle being left.
  task automatic step();
    if (n % 4 == 3) begin
      snap_p1 = p1_seg;
      snap_p2 = p2_seg;
    end
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_pos(input int c);
    logic [7:0] one;
    int ix;
    one = 8'h01;
    ix = (c / 4) % 8;
    if (c % 4 == 0) return 8'hFF;
    return ~(one << ix);
  endfunction

  function automatic logic [6:0] exp_scan_disp(input int c);
    int ix;
    ix = (c / 4) % 8;
    if (c % 4 == 0) return 7'h00;
    if (ix >= 4) return snap_p1[(ix-4)*7 +: 7];
    return snap_p2[ix*7 +: 7];
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    n = 0;
    snap_p1 = '0;
    snap_p2 = '0;
    rst = 1'b0;
    p1_seg = {7'h66, 7'h4F, 7'h5B, 7'h06};
    p2_seg = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    mif.msg_req = 1'b0;
    mif.msg_seg = '0;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pos", seg_position, 8'hFF);
    check("rst_disp", seg_display, 7'h00);
    check("rst_gnt", mif.msg_gnt, 1'b0);
    check("rst_busy", mif.msg_busy, 1'b0);
    check("rst_state", mif.state_dbg, SCAN);
    rst = 1'b1;
    n = 0;

    // two full scan frames
    for (int k = 0; k < 64; k++) begin
      step();
      check("scan_pos", seg_position, exp_pos(n));
      check("scan_disp", seg_display, exp_scan_disp(n));
      if (n == 2) check("pre_snap_zero", seg_display, 7'h00);
      if (n == 18) begin
        check("p1d0_pos", seg_position, 8'hEF);
        check("p1d0_disp", seg_display, 7'h06);
      end
      if (n == 34) begin
        check("p2d0_pos", seg_position, 8'hFE);
        check("p2d0_disp", seg_display, 7'h3F);
      end
    end

    // input change mid-digit stays invisible until the next tick
    step();
    p2_seg[6:0] = 7'h7D;
    step();
    check("snap_hold1", seg_display, 7'h3F);
    step();
    check("snap_hold2", seg_display, 7'h3F);
    while (n < 98) begin
      step();
      check("scan2_pos", seg_position, exp_pos(n));
      check("scan2_disp", seg_display, exp_scan_disp(n));
      if (n == 97) check("snap_new", seg_display, 7'h7D);
    end
    step();

    // grant on a tick cycle (n=99): that tick is not counted
    mif.msg_req = 1'b1;
    mif.msg_seg = {8{7'h79}};
    #1;
    check("gnt1", mif.msg_gnt, 1'b1);
    check("gnt1_busy", mif.msg_busy, 1'b0);
    check("gnt1_disp", seg_display, 7'h7D);
    while (n < 163) begin
      step();
      check("ovl_busy", mif.msg_busy, 1'b1);
      check("ovl_gnt", mif.msg_gnt, 1'b0);
      check("ovl_pos", seg_position, exp_pos(n));
      check("ovl_disp", seg_display, (n % 4 == 0) ? 7'h00 : 7'h79);
      if (n == 110) mif.msg_seg = '0;
    end

    // cooldown: request still held, no grant for 32 cycles
    while (n < 195) begin
      step();
      check("cool_busy", mif.msg_busy, 1'b0);
      check("cool_gnt", mif.msg_gnt, 1'b0);
      check("cool_disp", seg_display, exp_scan_disp(n));
    end
    check("cool_state", mif.state_dbg, COOLDOWN);
    step();
    mif.msg_seg = {8{7'h6D}};
    #1;
    check("gnt2", mif.msg_gnt, 1'b1);
    check("gnt2_state", mif.state_dbg, SCAN);
    step();
    mif.msg_req = 1'b0;
    check("gnt2_busy", mif.msg_busy, 1'b1);
    step();
    check("ovl2_pos", seg_position, 8'hFD);
    check("ovl2_disp", seg_display, 7'h6D);

    // abort on overlay tick 5 (n=215)
    while (n < 215) step();
    rst = 1'b0;
    step();
    check("abort_pos", seg_position, 8'hFF);
    check("abort_disp", seg_display, 7'h00);
    check("abort_busy", mif.msg_busy, 1'b0);
    check("abort_gnt", mif.msg_gnt, 1'b0);
    check("abort_state", mif.state_dbg, SCAN);
    step();
    rst = 1'b1;
    n = 0;
    snap_p1 = '0;
    snap_p2 = '0;
    mif.msg_req = 1'b1;
    mif.msg_seg = {8{7'h3F}};
    #1;
    check("post_rst_gnt", mif.msg_gnt, 1'b1);
    step();
    mif.msg_req = 1'b0;
    check("post_rst_busy", mif.msg_busy, 1'b1);
    check("post_rst_gnt_off", mif.msg_gnt, 1'b0);
    check("post_rst_pos", seg_position, 8'hFE);
    check("post_rst_disp", seg_display, 7'h3F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg_scan_arbiter.md
SEG_SCAN_ARBITER -- requirements
Module: seg_scan_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000: clk cycles per scan tick; legal range 2..2^20.
REQ-002 SHALL have parameter BLANK_CYC, default 4: blanking cycles after each tick; SHALL satisfy BLANK_CYC < CLK_DIV.
REQ-003 SHALL have parameter OVL_TICKS, default 2048: scan ticks an overlay holds the display.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port p1_seg, input, 28: player-1 digits; [7d+6:7d] = digit d, active-high segments.
REQ-007 SHALL have port p2_seg, input, 28: player-2 digits, same packing as p1_seg.
REQ-008 SHALL have port msg_req, input, 1: overlay request, level, held until granted.
REQ-009 SHALL have port msg_seg, input, 56: overlay digits; [7i+6:7i] = position i.
REQ-010 SHALL have port msg_gnt, output, 1: one-cycle grant pulse.
REQ-011 SHALL have port msg_busy, output, 1: high while the overlay owns the display.
REQ-012 SHALL have port seg_display, output, 7: segment drive, active-high.
REQ-013 SHALL have port seg_position, output, 8: digit enable, one-hot active-low; 8'hFF = none.

Function
REQ-014 Divider SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be high in the cycle the count equals CLK_DIV-1.
REQ-015 Position index SHALL advance 0->1->...->7->0 in the cycle after each tick.
REQ-016 On each tick, p1_seg and p2_seg SHALL be snapshot into registers; display SHALL use only the snapshots.
REQ-017 For BLANK_CYC cycles after each tick, seg_position SHALL be 8'hFF and seg_display 7'h00; afterwards seg_position[i]=0 for current index i until the next tick.
REQ-018 States: SCAN, OVERLAY, COOLDOWN.
REQ-019 In SCAN and COOLDOWN, position i in 4..7 SHALL show p1 digit i-4, and position i in 0..3 SHALL show p2 digit i.
REQ-020 In OVERLAY, position i SHALL show latched msg_seg digit i.
REQ-021 SCAN->OVERLAY SHALL occur in any cycle with msg_req=1; the same cycle SHALL pulse msg_gnt and latch msg_seg.
REQ-022 msg_busy SHALL be 1 from the cycle after the grant until OVERLAY exits.
REQ-023 OVERLAY->COOLDOWN SHALL occur on the OVL_TICKS-th tick after the grant; a tick coincident with the grant is not counted.
REQ-024 COOLDOWN->SCAN SHALL occur after 8 ticks; msg_req SHALL be ignored in OVERLAY and COOLDOWN, with no grant and no queueing.
REQ-025 Changes to msg_seg after the grant SHALL have no effect.
REQ-026 The divider and index SHALL run continuously across all state changes; a state change SHALL NOT reset the scan.

Reset
REQ-027 While rst=0 at a clk edge, the block SHALL load: state SCAN, divider 0, index 0, snapshots 0, overlay latch 0, msg_gnt 0, msg_busy 0, seg_display 7'h00, seg_position 8'hFF.
REQ-028 Reset during OVERLAY or COOLDOWN SHALL abort it; the first post-reset cycle with msg_req=1 SHALL be grantable.

Structure
REQ-029 Shared package seg_pkg SHALL hold the state enum, NUM_DIGITS=8, SEG_W=7 and POS_NONE=8'hFF.
REQ-030 Divider and blanking counter SHALL be one sub-module, seg_scan_timer, with outputs tick and blank.

Verification (CLK_DIV=4, BLANK_CYC=1, OVL_TICKS=16)
REQ-031 Reset: rst=0 for 3 cycles -> seg_position=8'hFF, seg_display=0, msg_gnt=0, msg_busy=0.
REQ-032 Scan: p1_seg digit0=7'h06, p2_seg digit0=7'h3F -> position 4 (8'hEF) shows 7'h06 and position 0 (8'hFE) shows 7'h3F; each digit is blank 1 cycle then driven 3; frame period is 32 cycles.
REQ-033 Grant: msg_req=1 with msg_seg=all 7'h79 -> msg_gnt pulses 1 cycle; all 8 positions show 7'h79 for 16 ticks (64 cycles); msg_busy then falls.
REQ-034 Cooldown: msg_req held high -> no second msg_gnt until 8 ticks (32 cycles) after msg_busy falls; then msg_gnt pulses.
REQ-035 Snapshot: change p1_seg mid-digit -> seg_display is unchanged until the next tick; change msg_seg during overlay -> no visible change.
REQ-036 Abort: rst=0 during overlay tick 5 -> outputs return to reset values; msg_req=1 after rst=1 -> immediate grant.
